// File: rtl/dmem_pkg.sv
// Shared definitions for the byte-enabled data memory: access-size codes and clear FSM states.
package dmem_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    localparam logic [1:0] SZ_BAD  = 2'b11;

    typedef enum logic {
        CLEAR = 1'b0,
        IDLE  = 1'b1
    } state_t;

    // Byte lanes touched by an access of the given size at the given lane.
    function automatic logic [3:0] lane_mask(input logic [1:0] size, input logic [1:0] lane);
        case (size)
            SZ_BYTE: lane_mask = 4'b0001 << lane;
            SZ_HALF: lane_mask = lane[1] ? 4'b1100 : 4'b0011;
            default: lane_mask = 4'b1111;
        endcase
    endfunction

endpackage

// File: rtl/dmem_load_align.sv
// Load path: picks the byte/half/word out of the addressed memory word and sign- or zero-extends it.
module dmem_load_align
    import dmem_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  lane,
    input  logic [1:0]  size,
    input  logic        sign,
    output logic [31:0] data
);

    logic [7:0]  byte_v;
    logic [15:0] half_v;

    assign byte_v = word[{lane, 3'b000} +: 8];
    assign half_v = word[{lane[1], 4'b0000} +: 16];

    always_comb begin
        // NOTE: assign a default before the case so every path drives data and no latch is inferred.
        data = word;
        case (size)
            SZ_BYTE: data = {{24{sign & byte_v[7]}}, byte_v};
            SZ_HALF: data = {{16{sign & half_v[15]}}, half_v};
            default: data = word;
        endcase
    end

endmodule

// File: rtl/dmem_be.sv
// Byte-enabled data memory acting on the falling clock edge, with a self-clear engine after reset.
// Define DMEM_BOUNDS_CHECK_EN to flag accesses outside the DEPTH-word window on err_range.
module dmem_be
    import dmem_pkg::*;
#(
    parameter logic [31:0] ADDR_BASE = 32'h10010000,
    parameter int          DEPTH     = 2048
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        write,
    input  logic        read,
    input  logic [1:0]  size,
    input  logic        sign,
    input  logic [31:0] addr,
    input  logic [31:0] idata,
    output logic [31:0] odata,
    output logic        busy,
    output logic        err_misalign,
    output logic        err_range
);

    localparam int AW = $clog2(DEPTH);

    state_t          state, state_nx;
    logic [AW-1:0]   ptr, ptr_nx;
    logic            clear_en;

    logic [31:0]     mem [DEPTH];
    logic [31:0]     off;
    logic [AW-1:0]   idx;
    logic [1:0]      lane;
    logic [31:0]     word;
    logic [31:0]     load_data;
    logic            access;
    logic [3:0]      be;
    logic [31:0]     wdata;
    logic [31:0]     merged;
    logic            store_en;

    assign off    = addr - ADDR_BASE;
    assign idx    = AW'(off >> 2);
    assign lane   = off[1:0];
    assign word   = mem[idx];
    assign access = (read | write) & ~busy;

    // Clear engine: state register.
    always_ff @(negedge clk or posedge rst) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (rst) begin
            state <= CLEAR;
            ptr   <= '0;
        end else begin
            state <= state_nx;
            ptr   <= ptr_nx;
        end
    end

    always_comb begin
        state_nx = state;
        ptr_nx   = ptr;
        if (state == CLEAR) begin
            ptr_nx = ptr + 1'b1;
            if (ptr == AW'(DEPTH - 1))
                state_nx = IDLE;
        end
    end

    always_comb begin
        busy     = (state == CLEAR);
        clear_en = busy & ~rst;
    end

    always_comb begin
        err_misalign = 1'b0;
        if (access) begin
            case (size)
                SZ_HALF: err_misalign = off[0];
                SZ_WORD: err_misalign = |off[1:0];
                SZ_BAD:  err_misalign = 1'b1;
                default: err_misalign = 1'b0;
            endcase
        end
    end

`ifdef DMEM_BOUNDS_CHECK_EN
    assign err_range = access & (off >= 32'(DEPTH * 4));
`else
    assign err_range = 1'b0;
`endif

    // Store data is replicated across lanes so the lane mask alone selects what lands.
    always_comb begin
        be     = lane_mask(size, lane);
        wdata  = idata;
        case (size)
            SZ_BYTE: wdata = {4{idata[7:0]}};
            SZ_HALF: wdata = {2{idata[15:0]}};
            default: wdata = idata;
        endcase
        for (int i = 0; i < 4; i++)
            merged[i*8 +: 8] = be[i] ? wdata[i*8 +: 8] : word[i*8 +: 8];
    end

    assign store_en = write & ~busy & ~err_misalign & ~err_range;

    // NOTE: the array has no reset branch; the clear engine zeroes it one word per edge instead.
    always_ff @(negedge clk) begin
        if (clear_en)
            mem[ptr] <= '0;
        else if (store_en)
            mem[idx] <= merged;
    end

    dmem_load_align u_load_align (
        .word (word),
        .lane (lane),
        .size (size),
        .sign (sign),
        .data (load_data)
    );

    assign odata = busy ? 32'h0 : load_data;

endmodule

// File: tb/tb_dmem_be.sv
// Self-checking bench for dmem_be: clear engine, byte/half/word loads and stores, error flags.
// Expected load values go through a scoreboard queue; DMEM_BOUNDS_CHECK_EN selects range expectations.
module tb_dmem_be;

    localparam logic [31:0] BASE  = 32'h10010000;
    localparam int          DEPTH = 2048;
    localparam logic [1:0]  SB = 2'b00, SH = 2'b01, SW = 2'b10, SX = 2'b11;
`ifdef DMEM_BOUNDS_CHECK_EN
    localparam bit BOUNDS = 1'b1;
`else
    localparam bit BOUNDS = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        write = 1'b0;
    logic        read = 1'b0;
    logic [1:0]  size = SW;
    logic        sign = 1'b0;
    logic [31:0] addr = BASE;
    logic [31:0] idata = '0;
    logic [31:0] odata;
    logic        busy;
    logic        err_misalign;
    logic        err_range;

    int total = 0;
    int bad   = 0;
    logic [31:0] exp_q [$];

    typedef struct {
        logic [31:0] a;
        logic [1:0]  sz;
        logic        sg;
        logic [31:0] exp;
    } ld_t;

    typedef struct {
        logic [31:0] a;
        logic [1:0]  sz;
        logic        rd;
        logic        wr;
        logic        exp_err;
    } er_t;

    dmem_be #(.ADDR_BASE(BASE), .DEPTH(DEPTH)) dut (
        .clk          (clk),
        .rst          (rst),
        .write        (write),
        .read         (read),
        .size         (size),
        .sign         (sign),
        .addr         (addr),
        .idata        (idata),
        .odata        (odata),
        .busy         (busy),
        .err_misalign (err_misalign),
        .err_range    (err_range)
    );

    always #5 clk = ~clk;

    // Drives one store across a falling edge.
    task automatic store(input logic [31:0] a, input logic [31:0] d, input logic [1:0] sz);
        @(posedge clk);
        addr = a; idata = d; size = sz; write = 1'b1; read = 1'b0;
        @(negedge clk);
        #1 write = 1'b0;
    endtask

    // Drives a load and records what it should return.
    task automatic issue_load(input logic [31:0] a, input logic [1:0] sz, input logic sg,
                              input logic [31:0] exp);
        @(posedge clk);
        addr = a; size = sz; sign = sg; read = 1'b1; write = 1'b0;
        exp_q.push_back(exp);
        #1;
    endtask

    task automatic test_reset;
        logic [31:0] e;
        rst = 1'b1; read = 1'b1; write = 1'b1; size = SX; addr = BASE + 32'd1;
        #1;
        total++;
        if (busy !== 1'b1 || err_misalign !== 1'b0 || err_range !== 1'b0 || odata !== 32'h0) begin
            bad++;
            $display("FAIL reset_state busy=%b mis=%b rng=%b odata=%h want 1 0 0 00000000",
                     busy, err_misalign, err_range, odata);
        end
        write = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        total++;
        if (busy !== 1'b1 || odata !== 32'h0) begin
            bad++;
            $display("FAIL reset_held busy=%b odata=%h want 1 00000000", busy, odata);
        end
        @(posedge clk) rst = 1'b0;
        for (int edge_n = 1; edge_n <= DEPTH; edge_n++) begin
            if (edge_n == 5) begin
                addr = BASE; size = SW; idata = 32'hDEADBEEF; write = 1'b1;
            end
            @(negedge clk);
            #1;
            if (edge_n == 5) begin
                write = 1'b0; addr = BASE + 32'd1; size = SX;
            end
            total++;
            if (busy !== (edge_n < DEPTH)) begin
                bad++;
                $display("FAIL clear_busy edge=%0d busy=%b want %b", edge_n, busy, edge_n < DEPTH);
            end
            if (edge_n < DEPTH) begin
                total++;
                if (odata !== 32'h0 || err_misalign !== 1'b0) begin
                    bad++;
                    $display("FAIL clear_outputs edge=%0d odata=%h mis=%b want 00000000 0",
                             edge_n, odata, err_misalign);
                end
            end
        end
        total++;
        if (err_misalign !== 1'b1) begin
            bad++;
            $display("FAIL flags_after_clear mis=%b want 1", err_misalign);
        end
        read = 1'b0; size = SW;
        for (int w = 0; w < DEPTH; w++) begin
            addr = BASE + 32'(4 * w); read = 1'b1;
            exp_q.push_back(32'h0);
            #1;
            e = exp_q.pop_front();
            total++;
            if (odata !== e) begin
                bad++;
                $display("FAIL cleared_word w=%0d got=%h want=%h", w, odata, e);
            end
        end
        read = 1'b0;
    endtask

    task automatic test_byte_lanes;
        ld_t tab[8];
        logic [31:0] e;
        tab = '{'{BASE + 32'h7, SB, 1'b1, 32'hFFFFFF88},
                '{BASE + 32'h4, SB, 1'b0, 32'h000000BB},
                '{BASE + 32'h4, SB, 1'b1, 32'hFFFFFFBB},
                '{BASE + 32'h5, SB, 1'b1, 32'hFFFFFFAA},
                '{BASE + 32'h6, SB, 1'b0, 32'h00000099},
                '{BASE + 32'h4, SH, 1'b1, 32'hFFFFAABB},
                '{BASE + 32'h6, SH, 1'b0, 32'h00008899},
                '{BASE + 32'h4, SW, 1'b1, 32'h8899AABB}};
        store(BASE + 32'h4, 32'h8899AABB, SW);
        for (int i = 0; i < 8; i++) begin
            issue_load(tab[i].a, tab[i].sz, tab[i].sg, tab[i].exp);
            e = exp_q.pop_front();
            total++;
            if (odata !== e) begin
                bad++;
                $display("FAIL byte_lanes idx=%0d got=%h want=%h", i, odata, e);
            end
        end
        read = 1'b0;
    endtask

    task automatic test_half;
        ld_t tab[5];
        logic [31:0] e;
        store(BASE + 32'h8, 32'h0, SW);
        store(BASE + 32'hA, 32'h1234F00D, SH);
        issue_load(BASE + 32'h8, SW, 1'b0, 32'hF00D0000);
        e = exp_q.pop_front();
        total++;
        if (odata !== e) begin
            bad++;
            $display("FAIL half_merge got=%h want=%h", odata, e);
        end
        store(BASE + 32'h8, 32'hABCDEF7F, SB);
        tab = '{'{BASE + 32'hA, SH, 1'b1, 32'hFFFFF00D},
                '{BASE + 32'hA, SH, 1'b0, 32'h0000F00D},
                '{BASE + 32'h8, SW, 1'b0, 32'hF00D007F},
                '{BASE + 32'h9, SB, 1'b1, 32'h00000000},
                '{BASE + 32'hB, SB, 1'b1, 32'hFFFFFFF0}};
        for (int i = 0; i < 5; i++) begin
            issue_load(tab[i].a, tab[i].sz, tab[i].sg, tab[i].exp);
            e = exp_q.pop_front();
            total++;
            if (odata !== e) begin
                bad++;
                $display("FAIL half_loads idx=%0d got=%h want=%h", i, odata, e);
            end
        end
        read = 1'b0;
    endtask

    task automatic test_misalign;
        er_t tab[7];
        logic [31:0] e;
        tab = '{'{BASE + 32'h2, SW, 1'b0, 1'b1, 1'b1},
                '{BASE + 32'h0, SX, 1'b0, 1'b1, 1'b1},
                '{BASE + 32'h1, SH, 1'b0, 1'b1, 1'b1},
                '{BASE + 32'h3, SH, 1'b1, 1'b0, 1'b1},
                '{BASE + 32'h2, SH, 1'b1, 1'b0, 1'b0},
                '{BASE + 32'h3, SB, 1'b1, 1'b0, 1'b0},
                '{BASE + 32'h1, SX, 1'b0, 1'b0, 1'b0}};
        store(BASE, 32'h11223344, SW);
        for (int i = 0; i < 7; i++) begin
            @(posedge clk);
            addr = tab[i].a; size = tab[i].sz; read = tab[i].rd; write = tab[i].wr;
            idata = 32'hDEADBEEF;
            #1;
            total++;
            if (err_misalign !== tab[i].exp_err) begin
                bad++;
                $display("FAIL misalign idx=%0d got=%b want=%b", i, err_misalign, tab[i].exp_err);
            end
            @(negedge clk);
            #1 write = 1'b0; read = 1'b0;
        end
        issue_load(BASE, SW, 1'b0, 32'h11223344);
        e = exp_q.pop_front();
        total++;
        if (odata !== e) begin
            bad++;
            $display("FAIL misalign_no_store got=%h want=%h", odata, e);
        end
        read = 1'b0;
    endtask

    task automatic test_range;
        logic [31:0] e;
        store(BASE, 32'h01020304, SW);
        @(posedge clk);
        addr = BASE + 32'(DEPTH * 4 - 4); size = SW; read = 1'b1; write = 1'b0;
        #1;
        total++;
        if (err_range !== 1'b0) begin
            bad++;
            $display("FAIL range_last_word got=%b want=0", err_range);
        end
        @(posedge clk);
        addr = BASE + 32'h2000; idata = 32'hCAFEBABE; size = SW; read = 1'b0; write = 1'b1;
        #1;
        total++;
        if (err_range !== BOUNDS) begin
            bad++;
            $display("FAIL range_flag got=%b want=%b", err_range, BOUNDS);
        end
        @(negedge clk);
        #1 write = 1'b0;
        issue_load(BASE, SW, 1'b0, BOUNDS ? 32'h01020304 : 32'hCAFEBABE);
        e = exp_q.pop_front();
        total++;
        if (odata !== e) begin
            bad++;
            $display("FAIL range_word0 got=%h want=%h", odata, e);
        end
        read = 1'b0;
    endtask

    task automatic test_same_cycle;
        store(BASE + 32'd80, 32'hAAAA5555, SW);
        @(posedge clk);
        addr = BASE + 32'd80; size = SW; idata = 32'h12345678; read = 1'b1; write = 1'b1;
        #1;
        total++;
        if (odata !== 32'hAAAA5555) begin
            bad++;
            $display("FAIL same_cycle_old got=%h want=aaaa5555", odata);
        end
        @(negedge clk);
        #1;
        write = 1'b0;
        total++;
        if (odata !== 32'h12345678) begin
            bad++;
            $display("FAIL same_cycle_new got=%h want=12345678", odata);
        end
        read = 1'b0;
    endtask

    task automatic test_back_to_back;
        logic [31:0] vals[8];
        logic [31:0] e;
        for (int i = 0; i < 8; i++) vals[i] = $urandom;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk);
            addr = BASE + 32'(4 * (32 + i)); idata = vals[i]; size = SW; write = 1'b1;
        end
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            addr = BASE + 32'(4 * 40 + i); idata = 32'hA5A5A500 | 32'(8'h11 * (i + 1)); size = SB;
        end
        @(negedge clk);
        #1 write = 1'b0;
        for (int i = 0; i < 8; i++) exp_q.push_back(vals[i]);
        exp_q.push_back(32'h44332211);
        for (int i = 0; i < 9; i++) begin
            @(posedge clk);
            addr = BASE + 32'(4 * (32 + i)); size = SW; read = 1'b1;
            #1;
            e = exp_q.pop_front();
            total++;
            if (odata !== e) begin
                bad++;
                $display("FAIL back_to_back idx=%0d got=%h want=%h", i, odata, e);
            end
        end
        read = 1'b0;
    endtask

    task automatic test_reset_mid_clear;
        int n;
        logic [31:0] e;
        store(BASE + 32'(4 * 5), 32'h5555AAAA, SW);
        store(BASE + 32'(4 * 1500), 32'h00001500, SW);
        @(posedge clk) rst = 1'b1;
        @(posedge clk) rst = 1'b0;
        repeat (1000) @(negedge clk);
        @(posedge clk) rst = 1'b1;
        #1;
        total++;
        if (busy !== 1'b1) begin
            bad++;
            $display("FAIL midclear_busy got=%b want=1", busy);
        end
        repeat (2) @(negedge clk);
        @(posedge clk) rst = 1'b0;
        n = 0;
        while (n < 2 * DEPTH) begin
            @(negedge clk);
            n++;
            #1;
            if (busy !== 1'b1) break;
        end
        total++;
        if (n != DEPTH) begin
            bad++;
            $display("FAIL midclear_edges got=%0d want=%0d", n, DEPTH);
        end
        exp_q.push_back(32'h0);
        exp_q.push_back(32'h0);
        for (int i = 0; i < 2; i++) begin
            @(posedge clk);
            addr = BASE + 32'(4 * (i == 0 ? 5 : 1500)); size = SW; read = 1'b1;
            #1;
            e = exp_q.pop_front();
            total++;
            if (odata !== e) begin
                bad++;
                $display("FAIL midclear_word idx=%0d got=%h want=%h", i, odata, e);
            end
        end
        read = 1'b0;
    endtask

    initial begin
        test_reset();
        test_byte_lanes();
        test_half();
        test_misalign();
        test_range();
        test_same_cycle();
        test_back_to_back();
        test_reset_mid_clear();
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL scoreboard_drain left=%0d want=0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/dmem_be.md
DMEM_BE -- requirements
Module: dmem_be

Interface
REQ-001 SHALL have parameter ADDR_BASE, default 32'h10010000, byte address of memory word 0.
REQ-002 SHALL have parameter DEPTH, default 2048, word count; power of two, at least 4.
REQ-003 SHALL have port clk  input  1  clock; all sequential logic acts on the falling edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port write  input  1  store strobe.
REQ-006 SHALL have port read  input  1  load strobe; qualifies error flags only.
REQ-007 SHALL have port size  input  2  access size: 00 byte, 01 half, 10 word, 11 illegal.
REQ-008 SHALL have port sign  input  1  1 = sign-extend loads, 0 = zero-extend.
REQ-009 SHALL have port addr  input  32  byte address.
REQ-010 SHALL have port idata  input  32  store data, right-justified.
REQ-011 SHALL have port odata  output  32  load data, combinational.
REQ-012 SHALL have port busy  output  1  clear engine running.
REQ-013 SHALL have port err_misalign  output  1  misaligned or illegal-size access.
REQ-014 SHALL have port err_range  output  1  address outside window (macro-dependent).

Function
REQ-015 SHALL compute off = addr - ADDR_BASE (32-bit, wrapping); word index = off[log2(DEPTH)+1:2]; lane = off[1:0].
REQ-016 SHALL drive odata combinationally from the indexed word: byte at lane*8, half at off[1]*16, or full word, extended per sign.
REQ-017 SHALL, on a falling edge with write=1, busy=0 and no error, update only the addressed byte lanes with the low bits of idata; other lanes keep their value.
REQ-018 SHALL assert err_misalign combinationally when (read|write) and (size=01 with off[0]=1, size=10 with off[1:0]!=0, or size=11).
REQ-019 SHALL suppress the store whenever err_misalign or err_range is asserted.
REQ-020 SHALL, with write and read on the same address and cycle, show old data before the falling edge and new data after it.
REQ-021 SHALL implement states CLEAR and IDLE; CLEAR writes 0 to word ptr on each falling edge, ptr increments, and the state moves to IDLE after word DEPTH-1 is written (DEPTH edges total).
REQ-022 SHALL hold busy=1 in CLEAR; writes are ignored and odata reads 32'h0 while busy; error flags read 0 while busy.

Reset
REQ-023 SHALL on rst=1 force state CLEAR, ptr 0, busy 1 immediately, with no clearing while rst is held.
REQ-024 SHALL restart the clear at ptr 0 on rst asserted mid-clear.
REQ-025 SHALL keep err_misalign and err_range at 0 and odata at 32'h0 while rst=1.

Configuration
REQ-026 SHALL, with DMEM_BOUNDS_CHECK_EN defined, assert err_range when (read|write) and off >= DEPTH*4.
REQ-027 SHALL, without DMEM_BOUNDS_CHECK_EN, tie err_range to 0; the index wraps modulo DEPTH.

Structure
REQ-028 SHALL place the size encodings (SZ_BYTE, SZ_HALF, SZ_WORD) and the state enum (CLEAR, IDLE) in the shared package dmem_pkg.
REQ-029 SHALL place load extraction and extension in combinational sub-module dmem_load_align; the store lane merge and clear FSM stay in dmem_be.

Verification
REQ-030 SHALL cover the following case: rst pulse, then DEPTH falling edges -> busy=1 throughout and 0 after edge DEPTH; every word reads 0; a write at edge 5 is ignored.
REQ-031 SHALL cover the following case: sw 32'h8899AABB at 0x10010004, then lb sign=1 at 0x10010007 -> odata 32'hFFFFFF88; lbu at 0x10010004 -> 32'h000000BB.
REQ-032 SHALL cover the following case: sw 32'h0 at 0x10010008, sh 32'h1234F00D at 0x1001000A -> word reads 32'hF00D0000; lh sign=1 at 0x1001000A -> 32'hFFFFF00D.
REQ-033 SHALL cover the following case: sw at 0x10010002, or size=11 at 0x10010000 -> err_misalign=1 and the memory is unchanged.
REQ-034 SHALL cover the following case, with the macro defined: sw at 0x10012000 (DEPTH 2048) -> err_range=1 and no store. Without the macro, the same store lands in word 0.
REQ-035 SHALL cover the following case: rst asserted at clear ptr 1000 -> busy stays 1 and the clear restarts at 0, finishing DEPTH edges after deassertion.
